div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer_if.sv | 30 +++
 rtl/div_sequencer.sv | 161 ++++++++++++++++
 tb/tb_div_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request/response bundle between a pipeline and the divider
//
// Signals:
//   start, is_signed, dividend, divisor, flush : requester -> divider
//   busy, done, quotient_out, rem_out           : divider -> requester
// Modports: master = requester (pipeline), slave = divider.

interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient_out;
    logic [WIDTH-1:0] rem_out;

    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  busy, done, quotient_out, rem_out
    );

    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output busy, done, quotient_out, rem_out
    );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - iterative RV32M divider (DIV/DIVU/REM/REMU), restoring, one bit per cycle
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div_sequencer_if.slave
//           start/is_signed/dividend/divisor sampled in IDLE or DONE
//           flush aborts any operation and returns to IDLE
//           busy high in CALC and FIXUP, done is a one-cycle pulse in DONE
//           quotient_out/rem_out registered, held until the next completion

module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    div_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [5:0]       cnt;
    logic [WIDTH-1:0] acc;      // partial remainder (magnitude)
    logic [WIDTH-1:0] quo;      // dividend bits shift out at the top, quotient bits enter at the bottom
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;

    // Operand decode, only meaningful while start is being sampled.
    logic             can_accept;
    logic             accept;
    logic             div_zero;
    logic             sgn_ovf;
    logic             special;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign can_accept = (state == IDLE) || (state == DONE);
    assign accept     = can_accept && bus.start && !bus.flush;
    assign div_zero   = (bus.divisor == '0);
    assign sgn_ovf    = bus.is_signed
                        && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                        && (bus.divisor == '1);
    assign special    = div_zero || sgn_ovf;
    assign a_neg      = bus.is_signed && bus.dividend[WIDTH-1];
    assign b_neg      = bus.is_signed && bus.divisor[WIDTH-1];
    assign a_mag      = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag      = b_neg ? -bus.divisor  : bus.divisor;

    // One restoring step. The shifted remainder needs one extra bit because a
    // divisor magnitude above 2^(WIDTH-1) can leave it wider than WIDTH bits.
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] diff;
    logic           fits;

    assign r_sh = {acc, quo[WIDTH-1]};
    assign diff = r_sh - {1'b0, dvs};
    assign fits = !diff[WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state_nxt = special ? DONE : CALC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                CALC: begin
                    if (cnt == 6'(WIDTH - 1)) begin
                        state_nxt = FIXUP;
                    end
                end
                FIXUP:   state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        bus.busy = (state == CALC) || (state == FIXUP);
        bus.done = (state == DONE);
    end

    assign bus.quotient_out = q_reg;
    assign bus.rem_out      = r_reg;

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q_reg <= '0;
            r_reg <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (div_zero) begin
                            q_reg <= '1;
                            r_reg <= bus.dividend;
                        end else if (sgn_ovf) begin
                            q_reg <= bus.dividend;
                            r_reg <= '0;
                        end else begin
                            acc   <= '0;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    acc <= fits ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                end
                FIXUP: begin
                    q_reg <= neg_q ? -quo : quo;
                    r_reg <= neg_r ? -acc : acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer with a reference model

module tb_div_sequencer;

    logic clk;
    logic rst_n;
    int   cyc;

    div_sequencer_if #(.WIDTH(32)) bus ();

    div_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_q   = 32'd0;
    logic [31:0] last_r   = 32'd0;
    int          exp_lat  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V M-extension division rules in plain arithmetic.
    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output int lat);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
            lat = 1;
        end else begin
            if (sgn) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = a / b;
                r = a % b;
            end
            lat = 34;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with nothing pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient", bus.quotient_out, e.q);
                check("remainder", bus.rem_out, e.r);
                check("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        exp_t        e;
        ref_div(sgn, a, b, q, r, lat);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        if (push) begin
            e.q = q;
            e.r = r;
            e.due = cyc + lat;
            exp_q.push_back(e);
            last_q  = q;
            last_r  = r;
            exp_lat = lat;
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_done(output int bc);
        bit got;
        bc  = 0;
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            if (bus.done) begin
                got = 1;
            end else begin
                if (bus.busy) bc++;
                @(negedge clk);
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within 100 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int bc;
        issue(sgn, a, b, 1'b1);
        wait_done(bc);
        check("busy_cycles", 32'(bc), 32'(exp_lat - 1));
    endtask

    initial begin
        int bc;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        bus.flush     = 1'b0;
        #3;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_q", bus.quotient_out, 32'd0);
        check("reset_r", bus.rem_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run(1'b0, 32'd100, 32'd7);
        run(1'b1, 32'hFFFF_FFF9, 32'd2);
        run(1'b0, 32'hFFFF_FFF9, 32'd2);
        repeat (3) @(negedge clk);
        run(1'b1, 32'd5, 32'd0);
        run(1'b0, 32'd5, 32'd0);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b1, 32'h8000_0000, 32'd1);
        run(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
        @(negedge clk);

        // Flush at CALC step 10, then an immediate 9/3
        issue(1'b0, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_hold_q", bus.quotient_out, last_q);
        check("flush_hold_r", bus.rem_out, last_r);
        run(1'b0, 32'd9, 32'd3);

        // Start pulse while busy must be ignored
        issue(1'b1, 32'hFFFF_FC18, 32'd13, 1'b1);
        repeat (5) @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd77;
        bus.divisor   = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bc);
        @(negedge clk);

        // Asynchronous reset mid-CALC
        issue(1'b0, 32'd12345, 32'd67, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_q", bus.quotient_out, 32'd0);
        check("midreset_r", bus.rem_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_q = 32'd0;
        last_r = 32'd0;
        repeat (40) @(negedge clk);

        // Randomized back-to-back traffic
        for (int i = 0; i < 30; i++) begin
            logic        sgn;
            logic [31:0] a;
            logic [31:0] b;
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 15);
                3:       b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run(sgn, a, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
